// File: rtl/prbs_checker_pkg.sv
// Shared types and the PRBS polynomial definition used by both the TX generator and the RX checker.
package prbs_checker_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } prbs_chk_state_t;

  localparam int CNT_WIDTH_DEF = 32;
  localparam int PRBS_MAX_N    = 32;

  // Feedback bit of x^n + x^tap + 1 for a register holding the last n bits, newest in bit 0.
  function automatic logic prbs_next(input logic [PRBS_MAX_N-1:0] sreg, input int n, input int tap);
    logic [PRBS_MAX_N-1:0] mask;
    mask = (PRBS_MAX_N'(1) << (n - 1)) | (PRBS_MAX_N'(1) << (tap - 1));
    return ^(sreg & mask);
  endfunction

endpackage

// File: rtl/prbs_checker_predict.sv
// Combinational PRBS bit predictor; instantiated at both ends of the link so they share one polynomial.
module prbs_checker_predict
  import prbs_checker_pkg::*;
#(
  parameter int PRBS_N   = 7,
  parameter int PRBS_TAP = 6
) (
  input  logic [PRBS_N-1:0] i_sreg,
  output logic              o_pred
);

  assign o_pred = prbs_next(PRBS_MAX_N'(i_sreg), PRBS_N, PRBS_TAP);

endmodule

// File: rtl/prbs_checker.sv
// RX PRBS bit-error monitor: self-synchronises to the incoming stream, then free-runs and counts errors.
// state  | meaning
// SEARCH | shifting in received bits, counting consecutive correct predictions
// LOCKED | free-running on predicted bits, counting checked bits and errors
module prbs_checker
  import prbs_checker_pkg::*;
#(
  parameter int PRBS_N        = 7,
  parameter int PRBS_TAP      = 6,
  parameter int LOCK_COUNT    = 64,
  parameter int UNLOCK_ERRS   = 8,
  parameter int UNLOCK_WINDOW = 128,
  parameter int CNT_WIDTH     = CNT_WIDTH_DEF
) (
  input  logic                 clk_sys,
  input  logic                 rst,
  input  logic                 i_cke,
  input  logic                 i_din,
  input  logic                 i_clear,
  input  logic                 i_hold,
  output logic                 o_locked,
  output logic                 o_err_flag,
  output logic [CNT_WIDTH-1:0] o_bit_count,
  output logic [CNT_WIDTH-1:0] o_err_count
);

  localparam int FILL_W  = $clog2(PRBS_N + 1);
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int WBITS_W = $clog2(UNLOCK_WINDOW);
  localparam int WERRS_W = $clog2(UNLOCK_ERRS + 1);

  localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(PRBS_N);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [WBITS_W-1:0] WBITS_LAST = WBITS_W'(UNLOCK_WINDOW - 1);
  localparam logic [WERRS_W-1:0] WERRS_LAST = WERRS_W'(UNLOCK_ERRS - 1);

  prbs_chk_state_t r_state, w_state_nxt;

  logic [PRBS_N-1:0]    r_sreg;
  logic [FILL_W-1:0]    r_fill;
  logic [MATCH_W-1:0]   r_match;
  logic [WBITS_W-1:0]   r_win_bits;
  logic [WERRS_W-1:0]   r_win_errs;
  logic                 r_err_flag;
  logic [CNT_WIDTH-1:0] r_bit_count;
  logic [CNT_WIDTH-1:0] r_err_count;

  logic w_pred, w_mismatch, w_filled, w_good, w_check, w_lock_now, w_unlock_now;

  prbs_checker_predict #(
    .PRBS_N   (PRBS_N),
    .PRBS_TAP (PRBS_TAP)
  ) u_predict (
    .i_sreg (r_sreg),
    .o_pred (w_pred)
  );

  assign w_mismatch   = i_din ^ w_pred;
  assign w_filled     = (r_fill == FILL_FULL);
  // An all-zero register predicts zero forever, so it must never count toward lock.
  assign w_good       = !w_mismatch && (r_sreg != '0);
  assign w_check      = i_cke && (r_state == LOCKED);
  assign w_lock_now   = i_cke && (r_state == SEARCH) && w_filled && w_good && (r_match == MATCH_LAST);
  assign w_unlock_now = w_check && w_mismatch && (r_win_errs == WERRS_LAST);

  always_ff @(posedge clk_sys) begin
    if (rst) r_state <= SEARCH;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == SEARCH) begin
      if (w_lock_now) w_state_nxt = LOCKED;
    end else begin
      if (w_unlock_now) w_state_nxt = SEARCH;
    end
  end

  always_comb begin
    o_locked = (r_state == LOCKED);
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_sreg     <= '0;
      r_fill     <= '0;
      r_match    <= '0;
      r_win_bits <= '0;
      r_win_errs <= '0;
    end else if (i_cke) begin
      if (r_state == SEARCH) begin
        r_sreg <= {r_sreg[PRBS_N-2:0], i_din};
        if (!w_filled)    r_fill  <= r_fill + 1'b1;
        else if (!w_good) r_match <= '0;
        else              r_match <= r_match + 1'b1;
        if (w_lock_now) begin
          r_win_bits <= '0;
          r_win_errs <= '0;
        end
      end else begin
        // Shifting in the prediction keeps one channel error from corrupting later predictions.
        r_sreg <= {r_sreg[PRBS_N-2:0], w_pred};
        if (w_unlock_now) begin
          r_fill  <= '0;
          r_match <= '0;
        end
        if (r_win_bits == WBITS_LAST) begin
          r_win_bits <= '0;
          r_win_errs <= '0;
        end else begin
          r_win_bits <= r_win_bits + 1'b1;
          r_win_errs <= r_win_errs + WERRS_W'(w_mismatch);
        end
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) r_err_flag <= 1'b0;
    else     r_err_flag <= w_check && w_mismatch;
  end

  always_ff @(posedge clk_sys) begin
    if (rst)                                         r_bit_count <= '0;
    else if (i_clear)                                r_bit_count <= '0;
    else if (w_check && !i_hold && !(&r_bit_count))  r_bit_count <= r_bit_count + 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (rst)                                                      r_err_count <= '0;
    else if (i_clear)                                             r_err_count <= '0;
    else if (w_check && w_mismatch && !i_hold && !(&r_err_count)) r_err_count <= r_err_count + 1'b1;
  end

  assign o_err_flag  = r_err_flag;
  assign o_bit_count = r_bit_count;
  assign o_err_count = r_err_count;

endmodule
